// File: rtl/coef_pkg.sv
// Shared constants, FSM state type and preset biquad table
// for the coefficient bank.
package coef_pkg;

  localparam int N_DEF   = 25;
  localparam int NCOEF   = 5;
  localparam int NPRESET = 6;

  localparam logic [2:0] A1 = 3'd0;
  localparam logic [2:0] A2 = 3'd1;
  localparam logic [2:0] B0 = 3'd2;
  localparam logic [2:0] B1 = 3'd3;
  localparam logic [2:0] B2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_TICK,
    SWAP
  } state_t;

  // Q4.20, order a1, a2, b0, b1, b2
  localparam logic [24:0] PRESET [NPRESET][NCOEF] = '{
    '{25'h1E0A3D7, 25'h00F5A1A, 25'h00000D1,
      25'h00001A1, 25'h00000D1},
    '{25'h1F2B3C4, 25'h0049A5E, 25'h0012A8B,
      25'h0025516, 25'h0012A8B},
    '{25'h00B1D2E, 25'h0037F4C, 25'h0065C3A,
      25'h00CB874, 25'h0065C3A},
    '{25'h1E01062, 25'h00FEF9F, 25'h00FF7CF,
      25'h1E01062, 25'h00FF7CF},
    '{25'h1E0A3D7, 25'h00F5A1A, 25'h0100000,
      25'h1E00000, 25'h0100000},
    '{25'h1F2B3C4, 25'h0049A5E, 25'h00B5EBC,
      25'h1E94288, 25'h00B5EBC}
  };

  function automatic logic [24:0] preset_word(
    input int slot,
    input int idx
  );
    preset_word = '0;
    if (slot < NPRESET && idx < NCOEF)
      preset_word = PRESET[3'(slot)][3'(idx)];
  endfunction

endpackage

// File: rtl/coef_bank_mem.sv
// Coefficient storage: one write port, one combinational
// read port, reset reloads the preset table.
module coef_bank_mem
  import coef_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int NFILT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [3:0]   wr_slot,
  input  logic [2:0]   wr_idx,
  input  logic [N-1:0] wr_data,
  input  logic [3:0]   rd_slot,
  input  logic [2:0]   rd_idx,
  output logic [N-1:0] rd_data
);

  localparam int SW = (NFILT > 1) ? $clog2(NFILT) : 1;

  logic [N-1:0] mem [NFILT][NCOEF];
  logic         wr_ok;
  logic         rd_ok;

  assign wr_ok = wr_en
              && (int'(wr_slot) < NFILT)
              && (wr_idx < 3'(NCOEF));

  assign rd_ok = (int'(rd_slot) < NFILT)
              && (rd_idx < 3'(NCOEF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NFILT; s++)
        for (int i = 0; i < NCOEF; i++)
          mem[SW'(s)][3'(i)] <=
            N'($signed(preset_word(s, i)));
    end else if (wr_ok) begin
      mem[wr_slot[SW-1:0]][wr_idx] <= wr_data;
    end
  end

  // out-of-range slots read as zero
  assign rd_data = rd_ok ? mem[rd_slot[SW-1:0]][rd_idx]
                         : '0;

endmodule

// File: rtl/coef_bank.sv
// Biquad coefficient bank: fetches a slot into shadow
// registers, then swaps all five outputs atomically.
module coef_bank
  import coef_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int NFILT     = 8,
  parameter int SYNC_SWAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   sel_in,
  input  logic         sel_valid,
  output logic         sel_ready,
  input  logic         wr_en,
  output logic         wr_ready,
  input  logic [3:0]   wr_slot,
  input  logic [2:0]   wr_idx,
  input  logic [N-1:0] wr_data,
  input  logic         sample_tick,
  output logic [N-1:0] a1,
  output logic [N-1:0] a2,
  output logic [N-1:0] b0,
  output logic [N-1:0] b1,
  output logic [N-1:0] b2,
  output logic         coef_valid,
  output logic         busy,
  output logic         swap_done
);

  state_t       state;
  state_t       state_n;
  logic [3:0]   sel_q;
  logic [2:0]   cnt;
  logic [N-1:0] rd_data;
  logic [N-1:0] shadow [NCOEF];
  logic [N-1:0] coef_q [NCOEF];

  coef_bank_mem #(
    .N     (N),
    .NFILT (NFILT)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && wr_ready),
    .wr_slot (wr_slot),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_slot (sel_q),
    .rd_idx  (cnt),
    .rd_data (rd_data)
  );

  assign sel_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state != FETCH);

  assign a1 = coef_q[A1];
  assign a2 = coef_q[A2];
  assign b0 = coef_q[B0];
  assign b1 = coef_q[B1];
  assign b2 = coef_q[B2];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (sel_valid) state_n = FETCH;
      FETCH:
        if (cnt == 3'(NCOEF - 1))
          state_n = (SYNC_SWAP != 0) ? WAIT_TICK
                                     : SWAP;
      WAIT_TICK:
        if (sample_tick) state_n = SWAP;
      SWAP:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      cnt        <= '0;
      coef_valid <= 1'b0;
      swap_done  <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow[3'(i)] <= '0;
        coef_q[3'(i)] <= '0;
      end
    end else begin
      swap_done <= 1'b0;
      if (state == IDLE && sel_valid) begin
        sel_q <= sel_in;
        cnt   <= '0;
      end
      if (state == FETCH) begin
        shadow[cnt] <= rd_data;
        cnt         <= cnt + 3'd1;
      end
      // all five words land on the same edge
      if (state == SWAP) begin
        for (int i = 0; i < NCOEF; i++)
          coef_q[3'(i)] <= shadow[3'(i)];
        coef_valid <= (int'(sel_q) < NFILT);
        swap_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coef_bank.sv
// Directed bench: a tick-synchronous and an immediate-swap
// instance share write/select inputs.
module tb_coef_bank;

  logic        clk;
  logic        reset;
  logic [3:0]  sel_in;
  logic        sel_valid_s;
  logic        sel_valid_a;
  logic        wr_en;
  logic [3:0]  wr_slot;
  logic [2:0]  wr_idx;
  logic [24:0] wr_data;
  logic        sample_tick;

  logic        sel_ready_s, wr_ready_s, coef_valid_s;
  logic        busy_s, swap_done_s;
  logic [24:0] a1_s, a2_s, b0_s, b1_s, b2_s;

  logic        sel_ready_a, wr_ready_a, coef_valid_a;
  logic        busy_a, swap_done_a;
  logic [24:0] a1_a, a2_a, b0_a, b1_a, b2_a;

  int checks = 0;
  int errors = 0;

  coef_bank #(.N(25), .NFILT(8), .SYNC_SWAP(1)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .sel_in      (sel_in),
    .sel_valid   (sel_valid_s),
    .sel_ready   (sel_ready_s),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready_s),
    .wr_slot     (wr_slot),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .sample_tick (sample_tick),
    .a1          (a1_s),
    .a2          (a2_s),
    .b0          (b0_s),
    .b1          (b1_s),
    .b2          (b2_s),
    .coef_valid  (coef_valid_s),
    .busy        (busy_s),
    .swap_done   (swap_done_s)
  );

  coef_bank #(.N(25), .NFILT(8), .SYNC_SWAP(0)) u_async (
    .clk         (clk),
    .reset       (reset),
    .sel_in      (sel_in),
    .sel_valid   (sel_valid_a),
    .sel_ready   (sel_ready_a),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready_a),
    .wr_slot     (wr_slot),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .sample_tick (sample_tick),
    .a1          (a1_a),
    .a2          (a2_a),
    .b0          (b0_a),
    .b1          (b1_a),
    .b2          (b2_a),
    .coef_valid  (coef_valid_a),
    .busy        (busy_a),
    .swap_done   (swap_done_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    sel_in      = '0;
    sel_valid_s = 1'b0;
    sel_valid_a = 1'b0;
    wr_en       = 1'b0;
    wr_slot     = '0;
    wr_idx      = '0;
    wr_data     = '0;
    sample_tick = 1'b0;
    repeat (2) step;

    // reset state
    chk("rst_a1", a1_s, 0);
    chk("rst_b0", b0_s, 0);
    chk("rst_b2", b2_s, 0);
    chk("rst_cv", coef_valid_s, 0);
    chk("rst_sel_ready", sel_ready_s, 1);
    chk("rst_wr_ready", wr_ready_s, 1);
    chk("rst_busy", busy_s, 0);
    chk("rst_swap_done", swap_done_s, 0);
    reset = 1'b0;
    step;

    // tick while idle does nothing
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    chk("idle_tick_busy", busy_s, 0);
    chk("idle_tick_sd", swap_done_s, 0);

    // slot 0, tick at T+10
    sel_in = 4'd0;
    sel_valid_s = 1'b1;
    step;
    sel_valid_s = 1'b0;
    chk("s0_sel_ready", sel_ready_s, 0);
    chk("s0_busy", busy_s, 1);
    for (int k = 1; k <= 9; k++) begin
      step;
      chk("s0_hold_a1", a1_s, 0);
    end
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    chk("s0_t10_a1", a1_s, 0);
    chk("s0_t10_sd", swap_done_s, 0);
    step;
    chk("s0_a1", a1_s, 32'h1E0A3D7);
    chk("s0_b0", b0_s, 32'h00000D1);
    chk("s0_b1", b1_s, 32'h00001A1);
    chk("s0_cv", coef_valid_s, 1);
    chk("s0_sd", swap_done_s, 1);
    step;
    chk("s0_sd_pulse", swap_done_s, 0);
    chk("s0_a1_held", a1_s, 32'h1E0A3D7);
    chk("s0_idle", sel_ready_s, 1);

    // invalid slot 9; request held high during fetch
    sel_in = 4'd9;
    sel_valid_s = 1'b1;
    step;
    sel_in = 4'd0;
    chk("s9_sel_ready", sel_ready_s, 0);
    repeat (3) begin
      step;
      chk("s9_fetch_ready", sel_ready_s, 0);
    end
    sel_valid_s = 1'b0;
    repeat (2) step;
    chk("s9_wait", busy_s, 1);
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    step;
    chk("s9_a1", a1_s, 0);
    chk("s9_a2", a2_s, 0);
    chk("s9_b0", b0_s, 0);
    chk("s9_b1", b1_s, 0);
    chk("s9_b2", b2_s, 0);
    chk("s9_cv", coef_valid_s, 0);
    chk("s9_sd", swap_done_s, 1);
    step;
    chk("s9_no_refetch", busy_s, 0);
    step;
    chk("s9_no_refetch2", busy_s, 0);

    // slot 4: early tick ignored, swap after T+20
    sel_in = 4'd4;
    sel_valid_s = 1'b1;
    step;
    sel_valid_s = 1'b0;
    repeat (2) step;
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    for (int k = 4; k <= 19; k++) begin
      step;
      chk("s4_hold_b0", b0_s, 0);
      chk("s4_hold_sd", swap_done_s, 0);
    end
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    chk("s4_t20_b0", b0_s, 0);
    step;
    chk("s4_b0", b0_s, 32'h0100000);
    chk("s4_b1", b1_s, 32'h1E00000);
    chk("s4_cv", coef_valid_s, 1);
    chk("s4_sd", swap_done_s, 1);

    // write slot 7 b0; slot 8 write must be dropped
    wr_en = 1'b1;
    wr_slot = 4'd7;
    wr_idx = 3'd2;
    wr_data = 25'h0100000;
    step;
    wr_slot = 4'd8;
    wr_idx = 3'd0;
    wr_data = 25'h00ABCDE;
    step;
    wr_en = 1'b0;

    // immediate swap on slot 7
    sel_in = 4'd7;
    sel_valid_a = 1'b1;
    step;
    sel_valid_a = 1'b0;
    chk("s7_wr_ready_fetch", wr_ready_a, 0);
    chk("s7_wr_ready_other", wr_ready_s, 1);
    wr_en = 1'b1;
    wr_idx = 3'd4;
    wr_data = 25'h0000055;
    wr_slot = 4'd7;
    step;
    wr_en = 1'b0;
    chk("s7_t1_sd", swap_done_a, 0);
    repeat (4) begin
      step;
      chk("s7_early_sd", swap_done_a, 0);
    end
    step;
    chk("s7_b0", b0_a, 32'h0100000);
    chk("s7_a1", a1_a, 0);
    chk("s7_a2", a2_a, 0);
    chk("s7_b1", b1_a, 0);
    chk("s7_b2_blocked_wr", b2_a, 0);
    chk("s7_cv", coef_valid_a, 1);
    chk("s7_sd", swap_done_a, 1);

    // slot 0 untouched by the slot-8 write
    sel_in = 4'd0;
    sel_valid_a = 1'b1;
    step;
    sel_valid_a = 1'b0;
    repeat (6) step;
    chk("alias_a1", a1_a, 32'h1E0A3D7);
    chk("alias_sd", swap_done_a, 1);

    // reset during WAIT_TICK after a bank write
    wr_en = 1'b1;
    wr_slot = 4'd0;
    wr_idx = 3'd0;
    wr_data = 25'h0012345;
    step;
    wr_en = 1'b0;
    sel_in = 4'd0;
    sel_valid_s = 1'b1;
    step;
    sel_valid_s = 1'b0;
    repeat (6) step;
    chk("mid_wait_busy", busy_s, 1);
    chk("mid_wait_b0", b0_s, 32'h0100000);
    reset = 1'b1;
    #2;
    chk("mid_rst_b0", b0_s, 0);
    chk("mid_rst_b1", b1_s, 0);
    chk("mid_rst_cv", coef_valid_s, 0);
    chk("mid_rst_ready", sel_ready_s, 1);
    chk("mid_rst_busy", busy_s, 0);
    chk("mid_rst_wr_ready", wr_ready_s, 1);
    step;
    reset = 1'b0;
    sel_valid_s = 1'b1;
    step;
    sel_valid_s = 1'b0;
    repeat (5) step;
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    step;
    chk("restored_a1", a1_s, 32'h1E0A3D7);
    chk("restored_cv", coef_valid_s, 1);
    chk("restored_sd", swap_done_s, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
